lcd_bus_rx: RTL and testbench

Responder/decoder for the 8-bit 8080-style write-only LCD bus (lcd_data, lcd_rs, lcd_wr) that our FPGA display drivers generate. It sits on the far end of that bus as a display-controller emulator for loopback and bus-sniffing. It decodes commands and their parameters, and tracks the CASET/PASET window. It assembles RAMWR byte pairs into 16-bit pixels tagged with x/y coordinates.

---
 rtl/lcd_bus_rx_if.sv | 9 +
 rtl/lcd_bus_rx.sv | 193 +++++++++++++++++++
 tb/tb_lcd_bus_rx.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_rx_if.sv
// 8080-style write-only LCD bus: 8-bit data, register select, active-low write strobe.
interface lcd_bus_rx_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_wr;

  modport master (output lcd_data, output lcd_rs, output lcd_wr);
  modport slave  (input  lcd_data, input  lcd_rs, input  lcd_wr);
endinterface

// File: rtl/lcd_bus_rx.sv
// Display-controller emulator on the far end of the LCD bus: decodes commands/parameters,
// tracks the CASET/PASET window and assembles RAMWR byte pairs into x/y-tagged pixels.
module lcd_bus_rx #(
  parameter int unsigned COLS           = 240,
  parameter int unsigned ROWS           = 320,
  parameter bit          LOW_BYTE_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  lcd_bus_rx_if.slave  bus,
  output logic         cmd_valid,
  output logic [7:0]   cmd_byte,
  output logic         param_valid,
  output logic [7:0]   param_byte,
  output logic [3:0]   param_idx,
  output logic         pixel_valid,
  output logic [15:0]  pixel_x,
  output logic [15:0]  pixel_y,
  output logic [15:0]  pixel_data,
  output logic         display_on,
  output logic         sleep_out,
  output logic         stray
);

  typedef enum logic [2:0] {NOCMD, CASET, PASET, RAMWR, OTHER} state_t;

  localparam logic [15:0] EC_RST = 16'(COLS - 1);
  localparam logic [15:0] EP_RST = 16'(ROWS - 1);

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_RAMWRC  = 8'h3C;

  // Input register plus one accepted-strobe stage; wr resets high so the first low after reset is an edge.
  logic [7:0] data_q, stb_data;
  logic       rs_q, wr_q, wr_q_d, stb, stb_rs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      rs_q     <= 1'b0;
      wr_q     <= 1'b1;
      wr_q_d   <= 1'b1;
      stb      <= 1'b0;
      stb_rs   <= 1'b0;
      stb_data <= '0;
    end else begin
      data_q   <= bus.lcd_data;
      rs_q     <= bus.lcd_rs;
      wr_q     <= bus.lcd_wr;
      wr_q_d   <= wr_q;
      stb      <= !wr_q && wr_q_d;
      stb_rs   <= rs_q;
      stb_data <= data_q;
    end
  end

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= NOCMD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stb && !stb_rs) begin
      case (stb_data)
        OP_CASET:             state_d = CASET;
        OP_PASET:             state_d = PASET;
        OP_RAMWR, OP_RAMWRC:  state_d = RAMWR;
        OP_SWRESET:           state_d = NOCMD;
        default:              state_d = OTHER;
      endcase
    end
  end

  logic do_cmd, do_stray, do_param, do_byte0, do_pixel;
  logic phase;

  always_comb begin
    do_cmd   = stb && !stb_rs;
    do_stray = 1'b0;
    do_param = 1'b0;
    do_byte0 = 1'b0;
    do_pixel = 1'b0;
    if (stb && stb_rs) begin
      case (state_q)
        NOCMD:               do_stray = 1'b1;
        RAMWR:               begin do_byte0 = !phase; do_pixel = phase; end
        CASET, PASET, OTHER: do_param = 1'b1;
        default:             do_stray = 1'b0;
      endcase
    end
  end

  // Staged window (written by CASET/PASET) and active window (loaded at RAMWR).
  logic [15:0] sc_s, ec_s, sp_s, ep_s, sc, ec, sp, ep, x_ptr, y_ptr;
  logic [15:0] x_nxt, y_nxt, pix_word;
  logic [7:0]  first_byte;
  logic [3:0]  p_cnt;

  always_comb begin
    pix_word = LOW_BYTE_FIRST ? {stb_data, first_byte} : {first_byte, stb_data};
    x_nxt    = x_ptr + 16'd1;
    y_nxt    = y_ptr;
    if (x_ptr >= ec) begin
      x_nxt = sc;
      y_nxt = (y_ptr >= ep) ? sp : y_ptr + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0; param_valid <= 1'b0; pixel_valid <= 1'b0; stray <= 1'b0;
      cmd_byte <= '0; param_byte <= '0; param_idx <= '0; p_cnt <= '0;
      pixel_x <= '0; pixel_y <= '0; pixel_data <= '0;
      display_on <= 1'b0; sleep_out <= 1'b0;
      sc_s <= '0; ec_s <= EC_RST; sp_s <= '0; ep_s <= EP_RST;
      sc <= '0; ec <= EC_RST; sp <= '0; ep <= EP_RST;
      x_ptr <= '0; y_ptr <= '0; phase <= 1'b0; first_byte <= '0;
    end else begin
      cmd_valid   <= do_cmd;
      param_valid <= do_param;
      pixel_valid <= do_pixel;
      stray       <= do_stray;
      if (do_cmd) begin
        cmd_byte  <= stb_data;
        param_idx <= '0;
        p_cnt     <= '0;
        phase     <= 1'b0;
        case (stb_data)
          OP_RAMWR: begin
            sc <= sc_s; ec <= ec_s; sp <= sp_s; ep <= ep_s;
            x_ptr <= sc_s; y_ptr <= sp_s;
          end
          OP_SWRESET: begin
            sc_s <= '0; ec_s <= EC_RST; sp_s <= '0; ep_s <= EP_RST;
            sc <= '0; ec <= EC_RST; sp <= '0; ep <= EP_RST;
            x_ptr <= '0; y_ptr <= '0;
            display_on <= 1'b0; sleep_out <= 1'b0;
          end
          OP_SLPOUT:  sleep_out  <= 1'b1;
          OP_SLPIN:   sleep_out  <= 1'b0;
          OP_DISPON:  display_on <= 1'b1;
          OP_DISPOFF: display_on <= 1'b0;
          default: ;
        endcase
      end
      if (do_param) begin
        param_byte <= stb_data;
        param_idx  <= p_cnt;
        if (p_cnt != 4'hF) p_cnt <= p_cnt + 4'd1;
        if (p_cnt < 4'd4) begin
          if (state_q == CASET) begin
            case (p_cnt[1:0])
              2'd0: sc_s[15:8] <= stb_data;
              2'd1: sc_s[7:0]  <= stb_data;
              2'd2: ec_s[15:8] <= stb_data;
              default: ec_s[7:0] <= stb_data;
            endcase
          end else if (state_q == PASET) begin
            case (p_cnt[1:0])
              2'd0: sp_s[15:8] <= stb_data;
              2'd1: sp_s[7:0]  <= stb_data;
              2'd2: ep_s[15:8] <= stb_data;
              default: ep_s[7:0] <= stb_data;
            endcase
          end
        end
      end
      if (do_byte0) begin
        first_byte <= stb_data;
        phase      <= 1'b1;
      end
      if (do_pixel) begin
        pixel_data <= pix_word;
        pixel_x    <= x_ptr;
        pixel_y    <= y_ptr;
        x_ptr      <= x_nxt;
        y_ptr      <= y_nxt;
        phase      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Bench for lcd_bus_rx: transaction-level reference model feeds expected-event queues
// that a negedge monitor scores against the DUT pulses.
module tb_lcd_bus_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_rx_if bus();

  logic        cmd_valid, param_valid, pixel_valid, display_on, sleep_out, stray;
  logic [7:0]  cmd_byte, param_byte;
  logic [3:0]  param_idx;
  logic [15:0] pixel_x, pixel_y, pixel_data;

  lcd_bus_rx #(.COLS(240), .ROWS(320), .LOW_BYTE_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .param_valid(param_valid), .param_byte(param_byte), .param_idx(param_idx),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_data(pixel_data),
    .display_on(display_on), .sleep_out(sleep_out), .stray(stray)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  exp_cmd[$];
  logic [11:0] exp_param[$];
  logic [47:0] exp_pix[$];
  int          exp_stray = 0;
  logic [47:0] obs_pix[$];
  int          obs_stray = 0;

  // Reference model: modes 0 none, 1 column, 2 page, 3 pixel stream, 4 other
  int          m_mode, m_idx;
  logic [15:0] m_sc_s, m_ec_s, m_sp_s, m_ep_s, m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  bit          m_phase, m_on, m_sleep;
  logic [7:0]  m_first;

  function automatic void model_window_reset();
    m_sc_s = 0; m_ec_s = 239; m_sp_s = 0; m_ep_s = 319;
    m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
    m_x = 0; m_y = 0;
  endfunction

  function automatic void model_reset();
    model_window_reset();
    m_mode = 0; m_idx = 0; m_phase = 0; m_on = 0; m_sleep = 0; m_first = 0;
    exp_cmd.delete(); exp_param.delete(); exp_pix.delete(); exp_stray = 0;
  endfunction

  function automatic void model_byte(input bit rs, input logic [7:0] d);
    logic [15:0] pix;
    if (!rs) begin
      exp_cmd.push_back(d);
      m_idx = 0; m_phase = 0;
      m_mode = 4;
      if (d == 8'h2A) m_mode = 1;
      if (d == 8'h2B) m_mode = 2;
      if (d == 8'h3C) m_mode = 3;
      if (d == 8'h2C) begin
        m_mode = 3;
        m_sc = m_sc_s; m_ec = m_ec_s; m_sp = m_sp_s; m_ep = m_ep_s;
        m_x = m_sc_s; m_y = m_sp_s;
      end
      if (d == 8'h01) begin m_mode = 0; model_window_reset(); m_on = 0; m_sleep = 0; end
      if (d == 8'h11) m_sleep = 1;
      if (d == 8'h10) m_sleep = 0;
      if (d == 8'h29) m_on = 1;
      if (d == 8'h28) m_on = 0;
    end else if (m_mode == 0) begin
      exp_stray++;
    end else if (m_mode == 3) begin
      if (!m_phase) begin
        m_first = d; m_phase = 1;
      end else begin
        pix = {d, m_first};
        exp_pix.push_back({m_x, m_y, pix});
        if (m_x >= m_ec) begin
          m_x = m_sc;
          m_y = (m_y >= m_ep) ? m_sp : m_y + 16'd1;
        end else begin
          m_x = m_x + 16'd1;
        end
        m_phase = 0;
      end
    end else begin
      exp_param.push_back({4'(m_idx), d});
      if (m_mode == 1 && m_idx == 0) m_sc_s[15:8] = d;
      if (m_mode == 1 && m_idx == 1) m_sc_s[7:0]  = d;
      if (m_mode == 1 && m_idx == 2) m_ec_s[15:8] = d;
      if (m_mode == 1 && m_idx == 3) m_ec_s[7:0]  = d;
      if (m_mode == 2 && m_idx == 0) m_sp_s[15:8] = d;
      if (m_mode == 2 && m_idx == 1) m_sp_s[7:0]  = d;
      if (m_mode == 2 && m_idx == 2) m_ep_s[15:8] = d;
      if (m_mode == 2 && m_idx == 3) m_ep_s[7:0]  = d;
      if (m_idx < 15) m_idx++;
    end
  endfunction

  function automatic int pending();
    return exp_cmd.size() + exp_param.size() + exp_pix.size() + exp_stray;
  endfunction

  // Scoreboard: every pulse is matched against the oldest expected event of its kind
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        n_cmp++;
        if (exp_cmd.size() == 0) begin
          n_fail++; $display("FAIL cmd_unexpected: got %h, want no command", cmd_byte);
        end else if (cmd_byte !== exp_cmd[0]) begin
          n_fail++; $display("FAIL cmd_byte: got %h, want %h", cmd_byte, exp_cmd[0]);
        end
        if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
      end
      if (param_valid) begin
        n_cmp++;
        if (exp_param.size() == 0) begin
          n_fail++; $display("FAIL param_unexpected: got idx %0d byte %h, want none", param_idx, param_byte);
        end else if ({param_idx, param_byte} !== exp_param[0]) begin
          n_fail++; $display("FAIL param: got idx %0d byte %h, want idx %0d byte %h",
                             param_idx, param_byte, exp_param[0][11:8], exp_param[0][7:0]);
        end
        if (exp_param.size() != 0) void'(exp_param.pop_front());
      end
      if (pixel_valid) begin
        n_cmp++;
        obs_pix.push_back({pixel_x, pixel_y, pixel_data});
        if (exp_pix.size() == 0) begin
          n_fail++; $display("FAIL pixel_unexpected: got (%0d,%0d) %h, want none", pixel_x, pixel_y, pixel_data);
        end else if ({pixel_x, pixel_y, pixel_data} !== exp_pix[0]) begin
          n_fail++; $display("FAIL pixel: got (%0d,%0d) %h, want (%0d,%0d) %h", pixel_x, pixel_y, pixel_data,
                             exp_pix[0][47:32], exp_pix[0][31:16], exp_pix[0][15:0]);
        end
        if (exp_pix.size() != 0) void'(exp_pix.pop_front());
      end
      if (stray) begin
        n_cmp++;
        obs_stray++;
        if (exp_stray == 0) begin
          n_fail++; $display("FAIL stray_unexpected: got stray pulse, want none");
        end else exp_stray--;
      end
    end
  end

  task automatic send(input bit rs, input logic [7:0] d, input int unsigned lo, input int unsigned hi);
    model_byte(rs, d);
    bus.lcd_rs = rs; bus.lcd_data = d; bus.lcd_wr = 1'b0;
    repeat (lo) @(negedge clk);
    bus.lcd_wr = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.lcd_wr = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    obs_pix.delete(); obs_stray = 0;
  endtask

  task automatic test_reset();
    do_reset();
    send(0, 8'h29, 1, 1); send(0, 8'h2A, 1, 1); send(1, 8'h77, 1, 1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cmd_valid, param_valid, pixel_valid, stray, display_on, sleep_out} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, want 000000",
                         {cmd_valid, param_valid, pixel_valid, stray, display_on, sleep_out});
    end
    n_cmp++;
    if ({cmd_byte, param_byte, param_idx, pixel_x, pixel_y, pixel_data} !== 68'h0) begin
      n_fail++; $display("FAIL reset_regs: got cmd %h param %h idx %0d xy %0d,%0d data %h, want all 0",
                         cmd_byte, param_byte, param_idx, pixel_x, pixel_y, pixel_data);
    end
    do_reset();
  endtask

  task automatic test_latency_flags();
    logic [7:0] ops [2];
    int first;
    bit f2, f3;
    ops[0] = 8'h11; ops[1] = 8'h29;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      model_byte(0, ops[k]);
      bus.lcd_rs = 1'b0; bus.lcd_data = ops[k]; bus.lcd_wr = 1'b0;
      first = 0; f2 = 0; f3 = 0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c == 1) bus.lcd_wr = 1'b1;
        if (cmd_valid && first == 0) first = c;
        if (c == 2) f2 = (k == 0) ? sleep_out : display_on;
        if (c == 3) f3 = (k == 0) ? sleep_out : display_on;
      end
      n_cmp++;
      if (first !== 3) begin
        n_fail++; $display("FAIL cmd_latency op %h: got pulse at cycle %0d, want 3", ops[k], first);
      end
      n_cmp++;
      if ({f2, f3} !== 2'b01) begin
        n_fail++; $display("FAIL flag_timing op %h: got %b, want 01", ops[k], {f2, f3});
      end
    end
    n_cmp++;
    if ({sleep_out, display_on, obs_stray} !== {2'b11, 32'd0}) begin
      n_fail++; $display("FAIL flags_after: got sleep %b on %b strays %0d, want 1 1 0", sleep_out, display_on, obs_stray);
    end
    n_cmp++;
    if (pending() !== 0) begin
      n_fail++; $display("FAIL latency_leftover: got %0d missing events, want 0", pending());
    end
  endtask

  task automatic test_stray();
    do_reset();
    send(1, 8'h55, 1, 1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs_stray !== 1 || obs_pix.size() !== 0) begin
      n_fail++; $display("FAIL stray_count: got %0d strays %0d pixels, want 1 0", obs_stray, obs_pix.size());
    end
    n_cmp++;
    if (pending() !== 0) begin
      n_fail++; $display("FAIL stray_leftover: got %0d missing events, want 0", pending());
    end
  endtask

  task automatic test_window();
    logic [47:0] want [5];
    do_reset();
    send(0, 8'h2A, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h01, 1, 1);
    send(0, 8'h2B, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h01, 1, 1);
    send(0, 8'h2C, 2, 1);
    for (int i = 0; i < 5; i++) begin
      send(1, 8'hE0, 1, 2);
      send(1, 8'h07, 2, 1);
    end
    repeat (6) @(negedge clk);
    want[0] = {16'd0, 16'd0, 16'h07E0}; want[1] = {16'd1, 16'd0, 16'h07E0};
    want[2] = {16'd0, 16'd1, 16'h07E0}; want[3] = {16'd1, 16'd1, 16'h07E0};
    want[4] = {16'd0, 16'd0, 16'h07E0};
    n_cmp++;
    if (obs_pix.size() !== 5) begin
      n_fail++; $display("FAIL window_count: got %0d pixels, want 5", obs_pix.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (obs_pix[i] !== want[i]) begin
          n_fail++; $display("FAIL window_pixel%0d: got %h, want %h", i, obs_pix[i], want[i]);
        end
      end
    end
    n_cmp++;
    if (pending() !== 0) begin
      n_fail++; $display("FAIL window_leftover: got %0d missing events, want 0", pending());
    end
  endtask

  task automatic test_discard();
    do_reset();
    send(0, 8'h2C, 1, 1); send(1, 8'hAB, 1, 1); send(0, 8'h00, 1, 1);
    send(0, 8'h3C, 1, 1); send(1, 8'h34, 1, 1); send(1, 8'h12, 1, 1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs_pix.size() !== 1 || obs_pix[0] !== {16'd0, 16'd0, 16'h1234}) begin
      n_fail++; $display("FAIL discard: got %0d pixels first %h, want 1 pixel %h",
                         obs_pix.size(), (obs_pix.size() != 0) ? obs_pix[0] : 48'h0, {16'd0, 16'd0, 16'h1234});
    end
    n_cmp++;
    if (pending() !== 0) begin
      n_fail++; $display("FAIL discard_leftover: got %0d missing events, want 0", pending());
    end
  endtask

  task automatic test_back_to_back_line();
    do_reset();
    send(0, 8'h2C, 1, 1);
    for (int i = 0; i < 482; i++) send(1, 8'($urandom), 1, 1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs_pix.size() !== 241) begin
      n_fail++; $display("FAIL line_count: got %0d pixels, want 241", obs_pix.size());
    end else begin
      n_cmp++;
      if (obs_pix[239][47:16] !== {16'd239, 16'd0} || obs_pix[240][47:16] !== {16'd0, 16'd1}) begin
        n_fail++; $display("FAIL line_wrap: got (%0d,%0d) then (%0d,%0d), want (239,0) then (0,1)",
                           obs_pix[239][47:32], obs_pix[239][31:16], obs_pix[240][47:32], obs_pix[240][31:16]);
      end
    end
    n_cmp++;
    if (pending() !== 0) begin
      n_fail++; $display("FAIL line_leftover: got %0d missing events, want 0", pending());
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [11];
    logic [7:0] op, b;
    int n;
    ops = '{8'h2A, 8'h2B, 8'h2C, 8'h3C, 8'h00, 8'h11, 8'h10, 8'h28, 8'h29, 8'h01, 8'h5A};
    do_reset();
    for (int it = 0; it < 60; it++) begin
      op = ops[$urandom_range(0, 10)];
      if (op == 8'h5A) op = 8'($urandom);
      send(0, op, $urandom_range(1, 3), $urandom_range(1, 3));
      if (op == 8'h2A || op == 8'h2B) n = $urandom_range(2, 6);
      else if (op == 8'h2C || op == 8'h3C) n = $urandom_range(0, 15);
      else n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if ((op == 8'h2A || op == 8'h2B) && i < 4) b = (i[0]) ? 8'($urandom_range(0, 4)) : 8'h00;
        send(1, b, $urandom_range(1, 3), $urandom_range(1, 3));
      end
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({display_on, sleep_out} !== {m_on, m_sleep}) begin
      n_fail++; $display("FAIL random_flags: got on %b sleep %b, want on %b sleep %b", display_on, sleep_out, m_on, m_sleep);
    end
    n_cmp++;
    if (pending() !== 0) begin
      n_fail++; $display("FAIL random_leftover: got %0d missing events, want 0", pending());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(0, 8'h29, 1, 1);
    send(0, 8'h2A, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h05, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'h07, 1, 1);
    send(0, 8'h2C, 1, 1); send(1, 8'h11, 1, 1);
    do_reset();
    send(0, 8'h2C, 1, 1); send(1, 8'h00, 1, 1); send(1, 8'hF8, 1, 1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs_pix.size() !== 1 || obs_pix[0] !== {16'd0, 16'd0, 16'hF800}) begin
      n_fail++; $display("FAIL reset_mid_pixel: got %0d pixels first %h, want 1 pixel %h",
                         obs_pix.size(), (obs_pix.size() != 0) ? obs_pix[0] : 48'h0, {16'd0, 16'd0, 16'hF800});
    end
    n_cmp++;
    if (display_on !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_display: got %b, want 0", display_on);
    end
    n_cmp++;
    if (pending() !== 0) begin
      n_fail++; $display("FAIL reset_mid_leftover: got %0d missing events, want 0", pending());
    end
  endtask

  initial begin
    bus.lcd_data = '0; bus.lcd_rs = 1'b0; bus.lcd_wr = 1'b1;
    model_reset();
    test_reset();
    test_latency_flags();
    test_stray();
    test_window();
    test_discard();
    test_back_to_back_line();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
